// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: one DIGIT-bit slice per cycle with carry chained between cycles.
// Define ALU_DIGIT_SERIAL_FLAGS_EN to add registered FlagZ/FlagN/FlagV outputs.
module alu_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [2:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutC,
  output logic             CarryOut
`ifdef ALU_DIGIT_SERIAL_FLAGS_EN
  ,
  output logic             FlagZ,
  output logic             FlagN,
  output logic             FlagV
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              carry_out_q, carry_out_d;
  logic              flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_v_q, flag_v_d;

  logic              is_sub, is_arith, last;
  logic [DIGIT-1:0]  a_dig, b_eff, logic_dig, digit;
  logic [DIGIT:0]    sum;
  logic [WIDTH-1:0]  res_shift;

  // Operands shift right each cycle so the active slice is always the low DIGIT bits.
  always_comb begin
    is_sub   = (op_q == OP_SUB);
    is_arith = (op_q == OP_ADD) || is_sub;
    last     = (cnt_q == CW'(N - 1));
    a_dig    = a_q[DIGIT-1:0];
    b_eff    = b_q[DIGIT-1:0] ^ {DIGIT{is_sub}};
    sum      = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
    case (op_q)
      OP_AND:  logic_dig = a_dig & b_q[DIGIT-1:0];
      OP_NAND: logic_dig = ~(a_dig & b_q[DIGIT-1:0]);
      OP_OR:   logic_dig = a_dig | b_q[DIGIT-1:0];
      OP_NOR:  logic_dig = ~(a_dig | b_q[DIGIT-1:0]);
      OP_XOR:  logic_dig = a_dig ^ b_q[DIGIT-1:0];
      OP_XNOR: logic_dig = ~(a_dig ^ b_q[DIGIT-1:0]);
      default: logic_dig = '0;
    endcase
    digit     = is_arith ? sum[DIGIT-1:0] : logic_dig;
    res_shift = (res_q >> DIGIT) | (WIDTH'(digit) << (WIDTH - DIGIT));
  end

  // NOTE: every _d gets a default from its _q first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    carry_out_d = carry_out_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    flag_v_d    = flag_v_q;
    case (state_q)
      IDLE: begin
        if (InValid && in_ready_q) begin
          a_d        = InA;
          b_d        = InB;
          op_d       = op_e'(Op);
          cnt_d      = '0;
          carry_d    = (Op == OP_SUB);
          res_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          carry_out_d = is_arith & sum[DIGIT];
          flag_z_d    = (res_shift == '0);
          flag_n_d    = res_shift[WIDTH-1];
          // Overflow: operand signs agree but the result sign differs.
          flag_v_d    = is_arith & (a_dig[DIGIT-1] == b_eff[DIGIT-1])
                                 & (sum[DIGIT-1] != a_dig[DIGIT-1]);
        end
      end
      DONE: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      carry_out_q <= carry_out_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_v_q    <= flag_v_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutC     = res_q;
  assign CarryOut = carry_out_q;

`ifdef ALU_DIGIT_SERIAL_FLAGS_EN
  assign FlagZ = flag_z_q;
  assign FlagN = flag_n_q;
  assign FlagV = flag_v_q;
`else
  logic unused_flags;
  assign unused_flags = flag_z_q ^ flag_n_q ^ flag_v_q;
`endif

endmodule

// File: doc/alu_digit_serial.md
ALU_DIGIT_SERIAL -- requirements
Module: alu_digit_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH mod DIGIT == 0 is required, and N = WIDTH/DIGIT.
REQ-003 SHALL have port Clk, input, 1, sole clock, all state updates on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port InValid, input, 1, operation request.
REQ-006 SHALL have port InReady, output, 1, block accepts a request.
REQ-007 SHALL have port InA, input, WIDTH, operand A.
REQ-008 SHALL have port InB, input, WIDTH, operand B.
REQ-009 SHALL have port Op, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 NAND, 100 OR, 101 NOR, 110 XOR, 111 XNOR.
REQ-010 SHALL have port OutValid, output, 1, result available.
REQ-011 SHALL have port OutReady, input, 1, consumer accepts the result.
REQ-012 SHALL have port OutC, output, WIDTH, result.
REQ-013 SHALL have port CarryOut, output, 1, final carry of ADD/SUB (SUB: 1 = no borrow); 0 for logic ops.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE, drive InReady=1; on InValid&InReady it SHALL latch InA, InB and Op, set the digit counter to 0, and preset the internal carry (1 for SUB, 0 otherwise), then go to RUN.
REQ-016 SHALL, in RUN, process one DIGIT-bit slice per cycle, LSB slice first, propagating the carry between cycles; SUB is computed as A + ~B + 1.
REQ-017 SHALL compute logic ops per bit with no carry involvement.
REQ-018 SHALL leave RUN for DONE on the cycle the counter equals N-1, and SHALL wrap the counter to 0.
REQ-019 SHALL assert OutValid exactly N cycles after the accepting edge; with N=1 (DIGIT==WIDTH), OutValid is asserted 1 cycle after acceptance.
REQ-020 SHALL, in DONE, hold OutValid, OutC, CarryOut and flags stable until OutValid&OutReady, then return to IDLE on that edge.
REQ-021 SHALL hold InReady=0 in RUN and DONE; InValid, InA, InB and Op SHALL be ignored there.
REQ-022 SHALL accept a new request no earlier than the cycle after the output handshake, giving a throughput of one op per N+2 cycles minimum.
REQ-023 SHALL treat OutReady held high before OutValid as an immediate handshake on the first DONE cycle.

Reset
REQ-024 SHALL, on Rst_n low at any time including mid-RUN or in DONE, immediately enter IDLE and clear all outputs and state: InReady=1 while in reset-released IDLE, OutValid=0, OutC=0, CarryOut=0, flags=0, counter=0.
REQ-025 SHALL discard an interrupted operation; no OutValid for it is ever produced.

Configuration
REQ-026 SHALL, with ALU_DIGIT_SERIAL_FLAGS_EN defined, add the following outputs, each 1 bit and registered alongside OutC:
- FlagZ: OutC==0.
- FlagN: OutC[WIDTH-1].
- FlagV: signed overflow for ADD/SUB, 0 for logic ops.
REQ-027 SHALL, without ALU_DIGIT_SERIAL_FLAGS_EN, omit those ports and their logic entirely; all other behaviour is identical.

Verification (WIDTH=32, DIGIT=4 unless noted)
REQ-028 SHALL cover: ADD 0xFFFFFFFF+0x00000001 -> OutC=0x00000000, CarryOut=1, OutValid 8 cycles after the accept edge.
REQ-029 SHALL cover: SUB 5-7 -> OutC=0xFFFFFFFE, CarryOut=0; SUB 7-5 -> OutC=0x00000002, CarryOut=1.
REQ-030 SHALL cover: NAND 0xF0F0F0F0,0xFF00FF00 -> 0x0FFF0FFF, CarryOut=0; with OutReady low for 5 cycles, outputs stay stable, InReady stays 0, and IDLE is entered on the handshake.
REQ-031 SHALL cover: Rst_n pulsed low at RUN counter=3 -> OutValid never rises for that op; the next ADD 2+3 returns 5.
REQ-032 SHALL cover: ALU_DIGIT_SERIAL_FLAGS_EN with ADD 0x7FFFFFFF+1 -> OutC=0x80000000, FlagV=1, FlagN=1, FlagZ=0; XOR A,A -> FlagZ=1, FlagV=0.
REQ-033 SHALL cover: DIGIT=32, back-to-back XNOR 0,0 requests -> OutC=0xFFFFFFFF, OutValid 1 cycle after each accept, one op per 3 cycles with OutReady=1.
